mux_in_x1_pipe: RTL and testbench

MUX_IN_X1_PIPE -- requirements
Module: mux_in_x1_pipe

---
 rtl/mux_in_x1_pipe.sv | 174 +++++++++++++++++
 tb/tb_mux_in_x1_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_in_x1_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_in_x1_pipe
// Description : N-to-1 channel select with a registered, back-pressurable
//               output stage (main register plus one skid register).
//               Out-of-range selects produce an all-zero beat flagged by
//               o_err, and set a sticky error flag that only reset clears.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk         in   1                      clock, rising edge
//   i_rst_n       in   1                      synchronous reset, active low
//   i_data        in   NUM_INPUTS*DATA_WIDTH  packed channels, ch k at
//                                            [k*DATA_WIDTH +: DATA_WIDTH]
//   i_control     in   SEL_WIDTH              channel select for this beat
//   i_valid       in   1                      upstream beat valid
//   o_ready       out  1                      block can accept a beat
//   o_data        out  DATA_WIDTH             selected, registered data
//   o_err         out  1                      this beat had a bad select
//   o_valid       out  1                      o_data/o_err hold a beat
//   i_ready       in   1                      downstream accepts the beat
//   o_err_sticky  out  1                      any bad select accepted
// ============================================================================
module mux_in_x1_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 3,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  input  logic [SEL_WIDTH-1:0]             i_control,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_err,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_err_sticky
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  generate
    if ((NUM_INPUTS < 2) || (NUM_INPUTS > 16) ||
        ((1 << SEL_WIDTH) < NUM_INPUTS)) begin : g_bad_params
      $error("mux_in_x1_pipe: illegal NUM_INPUTS/SEL_WIDTH combination");
    end
  endgenerate

  // One extra bit so that NUM_INPUTS == 2**SEL_WIDTH is representable.
  localparam logic [SEL_WIDTH:0] c_num_inputs = (SEL_WIDTH + 1)'(NUM_INPUTS);

  // --------------------------------------------------------------------------
  // Buffer states
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,   // no beat held
    ST_ONE   = 2'd1,   // main register holds a beat
    ST_FULL  = 2'd2    // main and skid registers both hold a beat
  } state_t;

  state_t                  state_q,      state_d;
  logic [DATA_WIDTH-1:0]   main_data_q,  main_data_d;
  logic                    main_err_q,   main_err_d;
  logic [DATA_WIDTH-1:0]   skid_data_q,  skid_data_d;
  logic                    skid_err_q,   skid_err_d;
  logic                    sticky_q,     sticky_d;

  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_err;
  logic                    accept;
  logic                    xfer_out;

  // --------------------------------------------------------------------------
  // Channel select. Out-of-range selects match no channel, so the default
  // of zero is what gets captured.
  // --------------------------------------------------------------------------
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (i_control == SEL_WIDTH'(k)) begin
        sel_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    sel_err = ({1'b0, i_control} >= c_num_inputs);
  end

  // --------------------------------------------------------------------------
  // Handshakes. o_ready is decoded from the state register only (plus the
  // reset input), so there is no combinational path from i_ready.
  // --------------------------------------------------------------------------
  assign o_ready  = (state_q != ST_FULL) && i_rst_n;
  assign o_valid  = (state_q != ST_EMPTY);
  assign accept   = i_valid && o_ready;
  assign xfer_out = o_valid && i_ready;

  assign o_data       = main_data_q;
  assign o_err        = main_err_q;
  assign o_err_sticky = sticky_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    // Sticky error tracks accepted beats, not delivered ones.
    sticky_d    = sticky_q | (accept & sel_err);

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_data_d = sel_data;
          main_err_d  = sel_err;
          state_d     = ST_ONE;
        end
      end

      ST_ONE: begin
        if (accept && xfer_out) begin
          main_data_d = sel_data;
          main_err_d  = sel_err;
        end else if (accept) begin
          // Downstream stalled: park the new beat behind the current one.
          skid_data_d = sel_data;
          skid_err_d  = sel_err;
          state_d     = ST_FULL;
        end else if (xfer_out) begin
          state_d     = ST_EMPTY;
        end
      end

      ST_FULL: begin
        if (xfer_out) begin
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
          state_d     = ST_ONE;
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      sticky_q    <= sticky_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_in_x1_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_in_x1_pipe
// Description : Directed bench for mux_in_x1_pipe: a default 3x32 instance
//               and a 16x8 instance, expected values written by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_in_x1_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: default parameters (3 channels x 32 bits)
  logic [95:0] a_data;
  logic [1:0]  a_ctl;
  logic        a_valid, a_rdy_in;
  logic        a_ready, a_err, a_ovalid, a_sticky;
  logic [31:0] a_odata;

  mux_in_x1_pipe u_dut_a (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (a_data),
    .i_control    (a_ctl),
    .i_valid      (a_valid),
    .o_ready      (a_ready),
    .o_data       (a_odata),
    .o_err        (a_err),
    .o_valid      (a_ovalid),
    .i_ready      (a_rdy_in),
    .o_err_sticky (a_sticky)
  );

  // Instance B: 16 channels x 8 bits
  logic [127:0] b_data;
  logic [3:0]   b_ctl;
  logic         b_valid, b_rdy_in;
  logic         b_ready, b_err, b_ovalid, b_sticky;
  logic [7:0]   b_odata;

  mux_in_x1_pipe #(.DATA_WIDTH(8), .NUM_INPUTS(16), .SEL_WIDTH(4)) u_dut_b (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (b_data),
    .i_control    (b_ctl),
    .i_valid      (b_valid),
    .o_ready      (b_ready),
    .o_data       (b_odata),
    .o_err        (b_err),
    .o_valid      (b_ovalid),
    .i_ready      (b_rdy_in),
    .o_err_sticky (b_sticky)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs and checks happen 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    a_data   = '0; a_ctl = '0; a_valid = 1'b0; a_rdy_in = 1'b1;
    b_data   = '0; b_ctl = '0; b_valid = 1'b0; b_rdy_in = 1'b1;
    step(); step();

    // ---- reset state ----
    check("rst_valid",  a_ovalid, 0);
    check("rst_data",   a_odata,  0);
    check("rst_err",    a_err,    0);
    check("rst_sticky", a_sticky, 0);
    check("rst_ready",  a_ready,  0);
    rst_n = 1'b1;
    #1;
    check("rel_ready",  a_ready,  1);

    // ---- single beat, channel 1 ----
    a_data   = {32'h0, 32'hDEADBEEF, 32'h0};
    a_ctl    = 2'd1;
    a_valid  = 1'b1;
    a_rdy_in = 1'b1;
    step();
    check("b1_valid", a_ovalid, 1);
    check("b1_data",  a_odata,  32'hDEADBEEF);
    check("b1_err",   a_err,    0);
    a_valid = 1'b0;
    step();
    check("b1_drain", a_ovalid, 0);

    // ---- streaming channels 0,1,2,0 ----
    a_valid = 1'b1;
    a_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}; a_ctl = 2'd0;
    step();
    check("s0_valid", a_ovalid, 1); check("s0_data", a_odata, 32'h1111_1111);
    check("s0_ready", a_ready, 1);
    a_data = {32'h6666_6666, 32'h5555_5555, 32'h4444_4444}; a_ctl = 2'd1;
    step();
    check("s1_valid", a_ovalid, 1); check("s1_data", a_odata, 32'h5555_5555);
    check("s1_ready", a_ready, 1);
    a_data = {32'h9999_9999, 32'h8888_8888, 32'h7777_7777}; a_ctl = 2'd2;
    step();
    check("s2_valid", a_ovalid, 1); check("s2_data", a_odata, 32'h9999_9999);
    check("s2_ready", a_ready, 1);
    a_data = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}; a_ctl = 2'd0;
    step();
    check("s3_valid", a_ovalid, 1); check("s3_data", a_odata, 32'hAAAA_AAAA);
    check("s3_ready", a_ready, 1);
    a_valid = 1'b0;
    step();
    check("s_drain", a_ovalid, 0);

    // ---- back-pressure: A then B while stalled ----
    a_rdy_in = 1'b0;
    a_valid  = 1'b1;
    a_data   = {32'h0, 32'h0, 32'hA0A0_A0A0}; a_ctl = 2'd0;
    step();
    check("bp_a_data",  a_odata, 32'hA0A0_A0A0);
    check("bp_a_ready", a_ready, 1);
    a_data   = {32'hB0B0_B0B0, 32'h0, 32'h0}; a_ctl = 2'd2;
    step();
    check("bp_full_ready", a_ready,  0);
    check("bp_full_data",  a_odata,  32'hA0A0_A0A0);
    check("bp_full_valid", a_ovalid, 1);
    // offered while full: must be ignored
    a_data   = {32'hEEEE_EEEE, 32'hEEEE_EEEE, 32'hEEEE_EEEE}; a_ctl = 2'd1;
    step();
    check("bp_stall_data",  a_odata, 32'hA0A0_A0A0);
    check("bp_stall_ready", a_ready, 0);
    a_valid  = 1'b0;
    a_rdy_in = 1'b1;
    step();
    check("bp_b_valid", a_ovalid, 1);
    check("bp_b_data",  a_odata,  32'hB0B0_B0B0);
    check("bp_b_ready", a_ready,  1);
    step();
    check("bp_drain", a_ovalid, 0);

    // ---- out-of-range select ----
    check("oor_sticky_pre", a_sticky, 0);
    a_valid = 1'b1;
    a_data  = {32'h1234_5678, 32'h1234_5678, 32'h1234_5678}; a_ctl = 2'd3;
    step();
    check("oor_valid",  a_ovalid, 1);
    check("oor_data",   a_odata,  0);
    check("oor_err",    a_err,    1);
    check("oor_sticky", a_sticky, 1);
    a_ctl = 2'd0;
    step();
    check("oor_next_err",    a_err,    0);
    check("oor_next_data",   a_odata,  32'h1234_5678);
    check("oor_next_sticky", a_sticky, 1);
    a_valid = 1'b0;
    step();
    check("oor_hold_sticky", a_sticky, 1);

    // ---- reset while FULL ----
    a_rdy_in = 1'b0;
    a_valid  = 1'b1;
    a_data   = {32'h0, 32'h0, 32'hC0C0_C0C0}; a_ctl = 2'd0;
    step();
    a_data   = {32'h0, 32'hD0D0_D0D0, 32'h0}; a_ctl = 2'd1;
    step();
    check("rf_full_ready", a_ready, 0);
    a_valid = 1'b0;
    rst_n   = 1'b0;
    step();
    check("rf_valid",  a_ovalid, 0);
    check("rf_sticky", a_sticky, 0);
    check("rf_data",   a_odata,  0);
    check("rf_ready",  a_ready,  0);
    rst_n    = 1'b1;
    a_rdy_in = 1'b1;
    #1;
    check("rf_rel_ready", a_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rf_no_ghost", a_ovalid, 0);
    end

    // ---- 16-channel walk on instance B ----
    for (int k = 0; k < 16; k++) begin
      b_data[k*8 +: 8] = {4'(k), ~4'(k)};
    end
    b_valid  = 1'b1;
    b_rdy_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      b_ctl = 4'(k);
      step();
      check("w16_data",  b_odata,  {56'h0, 4'(k), ~4'(k)});
      check("w16_err",   b_err,    0);
      check("w16_valid", b_ovalid, 1);
      check("w16_ready", b_ready,  1);
    end
    b_valid = 1'b0;
    step();
    check("w16_sticky", b_sticky, 0);
    check("w16_drain",  b_ovalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
